// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU arbiter slice.
package fpu_pkg;

   localparam int unsigned FPU_WIDTH = 64;
   localparam int unsigned OP_W      = 3;
   localparam int unsigned RND_W     = 2;
   localparam int unsigned FLAG_W    = 6;
   localparam int unsigned CNT_W     = 16;

   typedef logic [OP_W-1:0]  fpu_op_t;
   typedef logic [RND_W-1:0] fpu_rnd_t;

   // Field order matches the resp_flags port, MSB first.
   typedef struct packed {
      logic timeout;
      logic invalid;
      logic exception;
      logic inexact;
      logic overflow;
      logic underflow;
   } fpu_flags_t;

   localparam fpu_flags_t TIMEOUT_FLAGS = '{timeout: 1'b1, default: 1'b0};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2,
      GAP  = 2'd3
   } fpu_arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid index strictly after last, wrapping.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   int cand;

   // Scan NUM_REQ positions starting one past the previous winner.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         cand = (int'(last) + k) % int'(NUM_REQ);
         if (!any && valid[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter/sequencer sharing one FPU between NUM_REQ requesters.
module fpu_arbiter
   import fpu_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*OP_W-1:0]    req_op,
   input  logic [NUM_REQ*RND_W-1:0]   req_rnd,
   input  logic [NUM_REQ*FPU_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*FPU_WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]         resp_valid,
   output logic [FPU_WIDTH-1:0]       resp_data,
   output logic [FLAG_W-1:0]          resp_flags,
   output logic                       fpu_enable,
   output logic [OP_W-1:0]            fpu_operation,
   output logic [RND_W-1:0]           fpu_rounding,
   output logic [FPU_WIDTH-1:0]       fpu_operand_a,
   output logic [FPU_WIDTH-1:0]       fpu_operand_b,
   input  logic [FPU_WIDTH-1:0]       fpu_out,
   input  logic                       fpu_ready,
   input  logic                       fpu_underflow,
   input  logic                       fpu_overflow,
   input  logic                       fpu_inexact,
   input  logic                       fpu_exception,
   input  logic                       fpu_invalid,
   output logic                       busy
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   fpu_arb_state_e        state;
   logic [IDX_W-1:0]      last;
   logic [NUM_REQ-1:0]    owner_oh;
   logic [CNT_W-1:0]      cnt;
   fpu_op_t               hold_op;
   fpu_rnd_t              hold_rnd;
   logic [FPU_WIDTH-1:0]  hold_a;
   logic [FPU_WIDTH-1:0]  hold_b;
   fpu_flags_t            flags_q;
   fpu_flags_t            cap_flags;

   fpu_op_t               op_arr  [NUM_REQ];
   fpu_rnd_t              rnd_arr [NUM_REQ];
   logic [FPU_WIDTH-1:0]  a_arr   [NUM_REQ];
   logic [FPU_WIDTH-1:0]  b_arr   [NUM_REQ];

   logic [NUM_REQ-1:0]    pick_grant;
   logic [IDX_W-1:0]      pick_idx;
   logic                  pick_any;

   for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
      assign op_arr[i]  = req_op[i*OP_W +: OP_W];
      assign rnd_arr[i] = req_rnd[i*RND_W +: RND_W];
      assign a_arr[i]   = req_a[i*FPU_WIDTH +: FPU_WIDTH];
      assign b_arr[i]   = req_b[i*FPU_WIDTH +: FPU_WIDTH];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .valid (req_valid),
      .last  (last),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Accept is a same-cycle handshake, only offered in IDLE and never during reset.
   assign req_ready = (rst_n && (state == IDLE)) ? pick_grant : '0;

   assign fpu_operation = hold_op;
   assign fpu_rounding  = hold_rnd;
   assign fpu_operand_a = hold_a;
   assign fpu_operand_b = hold_b;
   assign resp_flags    = flags_q;

   // Pack the FPU status into the response flag layout (timeout clear).
   always_comb begin
      cap_flags           = '0;
      cap_flags.invalid   = fpu_invalid;
      cap_flags.exception = fpu_exception;
      cap_flags.inexact   = fpu_inexact;
      cap_flags.overflow  = fpu_overflow;
      cap_flags.underflow = fpu_underflow;
   end

   // Sequencer: grant, hold FPU inputs until ready or timeout, respond, then one idle gap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last       <= IDX_W'(NUM_REQ - 1);
         owner_oh   <= '0;
         cnt        <= '0;
         hold_op    <= '0;
         hold_rnd   <= '0;
         hold_a     <= '0;
         hold_b     <= '0;
         flags_q    <= '0;
         resp_data  <= '0;
         resp_valid <= '0;
         fpu_enable <= 1'b0;
         busy       <= 1'b0;
      end else begin
         resp_valid <= '0;
         unique case (state)
            IDLE: begin
               if (pick_any) begin
                  hold_op    <= op_arr[pick_idx];
                  hold_rnd   <= rnd_arr[pick_idx];
                  hold_a     <= a_arr[pick_idx];
                  hold_b     <= b_arr[pick_idx];
                  last       <= pick_idx;
                  owner_oh   <= pick_grant;
                  cnt        <= '0;
                  fpu_enable <= 1'b1;
                  busy       <= 1'b1;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (fpu_ready) begin
                  resp_data  <= fpu_out;
                  flags_q    <= cap_flags;
                  resp_valid <= owner_oh;
                  fpu_enable <= 1'b0;
                  state      <= RESP;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  resp_data  <= '0;
                  flags_q    <= TIMEOUT_FLAGS;
                  resp_valid <= owner_oh;
                  fpu_enable <= 1'b0;
                  state      <= RESP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: begin
               state <= GAP;
            end
            GAP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
